// File: rtl/cache_pkg.sv
// Shared cache geometry, line type and controller states for the data-memory port.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cache_pkg;

    localparam int WORD_W          = 32;
    localparam int LINE_WORDS      = 4;
    localparam int OFFSET_LSB      = 2;
    localparam int OFFSET_BITS     = 2;
    localparam int INDEX_LSB       = 4;
    localparam int LINE_ADDR_W     = WORD_W - INDEX_LSB;

    localparam int DEF_NUM_SETS    = 16;
    localparam int DEF_MEM_WORDS   = 16384;
    localparam int DEF_MEM_LATENCY = 8;

    typedef logic [LINE_WORDS-1:0][WORD_W-1:0] line_t;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WRITEBACK,
        ALLOCATE,
        RESPOND
    } state_t;

    // Lowest tag bit for a given number of sets; the CPU-side stall logic uses the same split.
    function automatic int tag_lsb(input int num_sets);
        return INDEX_LSB + $clog2(num_sets);
    endfunction

endpackage

// File: rtl/data_backing_mem.sv
// Backing word memory with whole-line read/write taking MEM_LATENCY cycles per transfer.
// Latency: o_done on the MEM_LATENCY-th cycle of a held request; write commits at that edge.
// Backpressure: caller holds i_rd or i_wr until o_done; dropping the request abandons it.
module data_backing_mem
    import cache_pkg::*;
#(
    parameter int MEM_WORDS   = DEF_MEM_WORDS,
    parameter int MEM_LATENCY = DEF_MEM_LATENCY
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_rd,
    input  logic                   i_wr,
    input  logic [LINE_ADDR_W-1:0] i_line_addr,
    input  line_t                  i_wr_line,
    output line_t                  o_rd_line,
    output logic                   o_done
);

    localparam int MW    = $clog2(MEM_WORDS);
    localparam int CNT_W = $clog2(MEM_LATENCY + 1);

    logic [WORD_W-1:0] r_mem [MEM_WORDS];
    logic [CNT_W-1:0]  r_cnt;

    logic                    w_busy;
    logic                    w_last;
    logic [WORD_W-OFFSET_LSB-1:0] w_word_addr;
    logic [MW-1:0]           w_base;
    logic                    w_unused;

    assign w_busy      = i_rd | i_wr;
    assign w_last      = (r_cnt == CNT_W'(MEM_LATENCY - 1));
    assign o_done      = w_busy & w_last;
    assign w_word_addr = {i_line_addr, {OFFSET_BITS{1'b0}}};
    // Word index wraps modulo MEM_WORDS by dropping the high word-address bits.
    assign w_base      = w_word_addr[MW-1:0];
    assign w_unused    = ^w_word_addr[WORD_W-OFFSET_LSB-1:MW];

    // Transfer counter: runs 0..MEM_LATENCY-1 while a request is held, restarts for the next one.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_busy && !w_last) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    // Storage: zero-filled on reset; a line write lands atomically at the end of its count.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (o_done && i_wr) begin
            for (int w = 0; w < LINE_WORDS; w++) begin
                r_mem[w_base + MW'(w)] <= i_wr_line[w];
            end
        end
    end

    for (genvar g = 0; g < LINE_WORDS; g++) begin : g_rd
        assign o_rd_line[g] = r_mem[w_base + MW'(g)];
    end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back write-allocate data cache behind a valid/ready load/store port.
// Latency: hit 2 cycles, clean miss 3+MEM_LATENCY, dirty miss 3+2*MEM_LATENCY (accept to pulse).
// Backpressure: is_ready only in IDLE; inputs outside IDLE are ignored, nothing is queued.
module data_cache
    import cache_pkg::*;
#(
    parameter int NUM_SETS    = DEF_NUM_SETS,
    parameter int MEM_WORDS   = DEF_MEM_WORDS,
    parameter int MEM_LATENCY = DEF_MEM_LATENCY
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              is_input_valid,
    input  logic [WORD_W-1:0] addr,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [WORD_W-1:0] din,
    output logic              is_ready,
    output logic              is_output_valid,
    output logic [WORD_W-1:0] dout,
    output logic              is_hit
);

    localparam int INDEX_BITS = $clog2(NUM_SETS);
    localparam int TAG_LSB    = tag_lsb(NUM_SETS);
    localparam int TAG_BITS   = WORD_W - TAG_LSB;

    state_t r_state, w_next;

    logic [WORD_W-1:0]   r_addr;
    logic [WORD_W-1:0]   r_din;
    logic                r_is_write;
    logic                r_first;
    logic                r_first_hit;

    logic [TAG_BITS-1:0] r_tag   [NUM_SETS];
    line_t               r_data  [NUM_SETS];
    logic [NUM_SETS-1:0] r_valid;
    logic [NUM_SETS-1:0] r_dirty;

    logic                r_out_vld;
    logic [WORD_W-1:0]   r_dout;
    logic                r_is_hit;

    logic                   w_accept;
    logic [INDEX_BITS-1:0]  w_index;
    logic [TAG_BITS-1:0]    w_tag;
    logic [OFFSET_BITS-1:0] w_off;
    logic                   w_hit;
    logic                   w_victim_dirty;
    logic                   w_mem_rd;
    logic                   w_mem_wr;
    logic                   w_mem_done;
    logic [LINE_ADDR_W-1:0] w_line_addr;
    line_t                  w_rd_line;
    logic                   w_unused;

    assign is_ready        = (r_state == IDLE) && !reset;
    assign is_output_valid = r_out_vld;
    assign dout            = r_dout;
    assign is_hit          = r_is_hit;

    assign w_accept       = is_ready && is_input_valid && (mem_read || mem_write);
    assign w_index        = r_addr[TAG_LSB-1:INDEX_LSB];
    assign w_tag          = r_addr[WORD_W-1:TAG_LSB];
    assign w_off          = r_addr[INDEX_LSB-1:OFFSET_LSB];
    assign w_hit          = r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_victim_dirty = r_valid[w_index] && r_dirty[w_index];
    assign w_mem_rd       = (r_state == ALLOCATE);
    assign w_mem_wr       = (r_state == WRITEBACK);
    // Write-back targets the victim's own address; a fill targets the requested line.
    assign w_line_addr    = w_mem_wr ? {r_tag[w_index], w_index} : {w_tag, w_index};
    assign w_unused       = ^r_addr[OFFSET_LSB-1:0];

    data_backing_mem #(
        .MEM_WORDS   (MEM_WORDS),
        .MEM_LATENCY (MEM_LATENCY)
    ) u_mem (
        .clk         (clk),
        .reset       (reset),
        .i_rd        (w_mem_rd),
        .i_wr        (w_mem_wr),
        .i_line_addr (w_line_addr),
        .i_wr_line   (r_data[w_index]),
        .o_rd_line   (w_rd_line),
        .o_done      (w_mem_done)
    );

    // Controller state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: a miss evicts (if dirty) then fills, then re-enters LOOKUP which now hits.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:      if (w_accept) w_next = LOOKUP;
            LOOKUP:    begin
                if (w_hit)               w_next = RESPOND;
                else if (w_victim_dirty) w_next = WRITEBACK;
                else                     w_next = ALLOCATE;
            end
            WRITEBACK: if (w_mem_done) w_next = ALLOCATE;
            ALLOCATE:  if (w_mem_done) w_next = LOOKUP;
            RESPOND:   w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    // Request latch; hit status is taken only from the first lookup of each request.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr      <= '0;
            r_din       <= '0;
            r_is_write  <= 1'b0;
            r_first     <= 1'b0;
            r_first_hit <= 1'b0;
        end else if (w_accept) begin
            r_addr      <= addr;
            r_din       <= din;
            r_is_write  <= mem_write;
            r_first     <= 1'b1;
        end else if (r_state == LOOKUP && r_first) begin
            r_first_hit <= w_hit;
            r_first     <= 1'b0;
        end
    end

    // Line state bits: fill marks the line clean and valid, a store hit marks it dirty.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (r_state == ALLOCATE && w_mem_done) begin
            r_valid[w_index] <= 1'b1;
            r_dirty[w_index] <= 1'b0;
        end else if (r_state == LOOKUP && w_hit && r_is_write) begin
            r_dirty[w_index] <= 1'b1;
        end
    end

    // Tag and data arrays; contents are meaningless until the valid bit is set.
    always_ff @(posedge clk) begin
        if (!reset && r_state == ALLOCATE && w_mem_done) begin
            r_tag[w_index]  <= w_tag;
            r_data[w_index] <= w_rd_line;
        end else if (!reset && r_state == LOOKUP && w_hit && r_is_write) begin
            r_data[w_index][w_off] <= r_din;
        end
    end

    // Response registers: one-cycle pulse after RESPOND; dout and is_hit hold between pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_vld <= 1'b0;
            r_dout    <= '0;
            r_is_hit  <= 1'b0;
        end else begin
            r_out_vld <= (r_state == RESPOND);
            if (r_state == RESPOND) begin
                r_dout   <= r_data[w_index][w_off];
                r_is_hit <= r_first_hit;
            end
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// Scoreboard bench for data_cache: stimulus pushes expected responses, a monitor checks pulses.
// Latency: checks the exact pulse cycle of every response.
// Backpressure: stimulus waits (bounded) for is_ready before each request.
module tb_data_cache;
    import cache_pkg::*;

    localparam int L = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        is_input_valid = 1'b0;
    logic [31:0] addr = '0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] din = '0;
    logic        is_ready;
    logic        is_output_valid;
    logic [31:0] dout;
    logic        is_hit;

    typedef struct {
        logic [31:0] d;
        logic        h;
        int          c;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   acc;

    data_cache #(.NUM_SETS(16), .MEM_WORDS(16384), .MEM_LATENCY(L)) dut (
        .clk             (clk),
        .reset           (reset),
        .is_input_valid  (is_input_valid),
        .addr            (addr),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .din             (din),
        .is_ready        (is_ready),
        .is_output_valid (is_output_valid),
        .dout            (dout),
        .is_hit          (is_hit)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Monitor: every response pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (!reset && is_output_valid) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_pulse: pulse at cycle %0d, expected none", cyc);
            end else begin
                e = q.pop_front();
                check("dout", dout, e.d);
                check("is_hit", {31'b0, is_hit}, {31'b0, e.h});
                check("pulse_cycle", cyc, e.c);
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic wr, input logic [31:0] d,
                         input logic exp_rsp, input logic [31:0] ed, input logic eh, input int lat);
        int budget;
        budget = 0;
        @(negedge clk);
        while (!is_ready && budget < 500) begin
            @(negedge clk);
            budget++;
        end
        if (!is_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL ready_timeout: is_ready=0 after %0d cycles, expected 1", budget);
            return;
        end
        is_input_valid = 1'b1;
        addr           = a;
        mem_write      = wr;
        mem_read       = !wr;
        din            = d;
        @(posedge clk);
        #1;
        acc = cyc;
        if (exp_rsp) q.push_back('{d: ed, h: eh, c: acc + lat});
        is_input_valid = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (q.size() != 0 && budget < 500) begin
            @(negedge clk);
            budget++;
        end
        if (q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: %0d responses outstanding, expected 0", q.size());
            q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        // Reset values while reset is held.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_is_ready", {31'b0, is_ready}, 32'd0);
        check("rst_out_valid", {31'b0, is_output_valid}, 32'd0);
        check("rst_dout", dout, 32'd0);
        check("rst_is_hit", {31'b0, is_hit}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_reset", {31'b0, is_ready}, 32'd1);

        // Cold miss, then store/load hits on the same line.
        issue(32'h100, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 3 + L);
        drain();
        issue(32'h104, 1'b1, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 1'b1, 2);
        drain();
        issue(32'h104, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF, 1'b1, 2);
        drain();

        // Dirty eviction by a conflicting line, then refill shows the write-back landed.
        issue(32'h100, 1'b1, 32'h11, 1'b1, 32'h11, 1'b1, 2);
        drain();
        issue(32'h200, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 3 + 2 * L);
        drain();
        issue(32'h100, 1'b0, 32'h0, 1'b1, 32'h11, 1'b0, 3 + L);
        drain();
        issue(32'h104, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF, 1'b1, 2);
        drain();

        // Valid with no operation is not accepted.
        is_input_valid = 1'b1;
        addr           = 32'h104;
        repeat (5) begin
            @(negedge clk);
            check("noop_ready", {31'b0, is_ready}, 32'd1);
        end
        is_input_valid = 1'b0;

        // Reset in the middle of a write-back abandons it.
        issue(32'h300, 1'b1, 32'h55, 1'b1, 32'h55, 1'b0, 3 + L);
        drain();
        issue(32'h300, 1'b0, 32'h0, 1'b1, 32'h55, 1'b1, 2);
        drain();
        issue(32'h400, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 0);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("wbrst_is_ready", {31'b0, is_ready}, 32'd0);
        check("wbrst_out_valid", {31'b0, is_output_valid}, 32'd0);
        check("wbrst_dout", dout, 32'd0);
        check("wbrst_is_hit", {31'b0, is_hit}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("wbrst_ready_after", {31'b0, is_ready}, 32'd1);
        issue(32'h300, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 3 + L);
        drain();

        // Back-to-back hits with the request held valid.
        issue(32'h104, 1'b1, 32'hCAFE, 1'b1, 32'hCAFE, 1'b0, 3 + L);
        drain();
        is_input_valid = 1'b1;
        addr           = 32'h104;
        mem_read       = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        for (int k = 0; k < 3; k++) q.push_back('{d: 32'hCAFE, h: 1'b1, c: acc + 2 + 3 * k});
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            check("b2b_ready", {31'b0, is_ready}, (k % 3 == 2) ? 32'd1 : 32'd0);
        end
        is_input_valid = 1'b0;
        mem_read       = 1'b0;
        drain();
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule
